ram4x4_arbiter: RTL and testbench
=================================

# ram4x4_arbiter

Two-port arbiter and sequencer for the 4-word × 4-bit register-file RAM. After reset it clears all four words. It then grants single-word read/write accesses to two requesters (A and B) with round-robin fairness. It drives the RAM's address, write data and write enable, and returns registered read data with a one-cycle acknowledge. The block sits between the two requesting datapaths and the RAM, and is the RAM's only master.

## Interface
Parameters:
- none (RAM geometry fixed: 4 words, 2-bit address, 4-bit data)

Ports:
- clk  in  1  single system clock; all state changes on posedge
- rst_n  in  1  reset, synchronous, active-low
- req_a / req_b  in  1  access request; held high until the matching ack
- we_a / we_b  in  1  1 = write, 0 = read; stable while req high
- addr_a / addr_b  in  2  word address; stable while req high
- wdata_a / wdata_b  in  4  write data; stable while req high
- ack_a / ack_b  out  1  one-cycle completion pulse
- rdata_a / rdata_b  out  4  read result; valid with ack, held until the next read by that port
- ram_addr  out  2  RAM address (drives write decode and read mux)
- ram_d  out  4  RAM write data
- ram_we  out  1  RAM write enable; RAM captures ram_d at posedge clk when high
- ram_q  in  4  RAM combinational read data for ram_addr
- init_done  out  1  high once the clear sweep has completed

## Operation
- States: INIT, IDLE, ACCESS, DONE.
- **INIT**
  - Entered on every clock edge with rst_n=0. The 2-bit init counter resets to 0.
  - Outputs: ram_addr = init counter, ram_d = 0, ram_we = 1.
  - The counter increments each cycle. After the cycle with counter = 3, the block goes to IDLE.
  - Requests are ignored during INIT: no ack is issued and requests are not queued.
- **IDLE**
  - ram_we = 0.
  - If req_a or req_b is high, the block latches the winner's owner bit, we, addr and wdata, then goes to ACCESS. Otherwise it stays in IDLE.
- **Arbitration**
  - Only one request high: that requester wins.
  - Both high: the requester not granted last wins.
  - The last-grant bit resets to B, so A wins the first tie after reset.
  - The last-grant bit is updated on entry to ACCESS.
- **ACCESS**
  - Outputs: ram_addr = latched addr, ram_d = latched wdata, ram_we = latched we.
  - On the clock edge, ram_q is captured into the owner's rdata register, for reads only.
  - A write leaves both rdata registers unchanged.
  - The block then goes to DONE.
- **DONE**
  - ack of the owner is high for this one cycle. ram_we = 0.
  - The block then goes to IDLE unconditionally.
- ack_a and ack_b are never high in the same cycle.
- ram_addr and ram_d hold their last value in IDLE and DONE. ram_we is 0 outside INIT and write ACCESS.

## Timing
- **Reset values**
  - state = INIT, init counter = 0, last-grant = B.
  - ack_a = ack_b = 0, rdata_a = rdata_b = 0, init_done = 0.
  - ram_addr = 0, ram_d = 0, ram_we = 1. Word 0 is rewritten with 0 while reset is held, which is harmless.
- init_done rises on the 4th clock edge after rst_n goes high, i.e. on entry to IDLE. All words read 0 from then on.
- **Latency**
  - Request sampled in IDLE at cycle T; ACCESS at T+1; ack and rdata at T+2; IDLE at T+3.
  - A write is visible in RAM from T+2.
- **Throughput:** one access per 3 cycles.
- **Handshake**
  - A requester must drop req, or present a new request, in the cycle after its ack.
  - A req still high at T+3 is treated as a new request.
  - With both requesters continuously asserting, grants alternate A, B, A, B, ...
- **Simultaneous events**
  - A request arriving during ACCESS or DONE waits for IDLE.
  - A losing requester keeps req high and is granted next.
- **Reset mid-operation:** rst_n=0 in ACCESS or DONE aborts the access. No ack is issued, rdata is cleared, and the clear sweep restarts.
- A write to the same address as a pending read by the other port is ordered by grant: whichever access is granted first completes first.

## Test plan
- **Reset/init:** hold rst_n=0 for 3 cycles, then release -> ram_we=1 with ram_addr 0,1,2,3 on consecutive cycles; init_done=1 on the 4th edge; a subsequent read of each address returns 0.
- **Single write/read:** A writes 4'hA to addr 2 at T -> ack_a at T+2; A reads addr 2 -> rdata_a=4'hA with ack_a, ack_b stays 0.
- **Tie arbitration:** first cycle after init, req_a=req_b=1 as reads of addr 1 and 3 -> ack_a first, then ack_b 3 cycles later. With both held high, the ack sequence is A, B, A, B.
- **Write-then-read across ports:** B writes 4'h5 to addr 0 and A reads addr 0, both requesting together, with last grant = A -> B granted first; A then gets rdata_a=4'h5.
- **Requests during INIT:** req_a=1 held from reset release -> no ack during INIT; first ack_a exactly 2 cycles after init_done rises.
- **Mid-op reset:** rst_n=0 during ACCESS of an A read -> no ack_a, rdata_a=0, init sweep repeats, RAM reads all 0 afterwards.

Source files
------------

// File: rtl/ram4x4_arbiter.sv
// Round-robin arbiter/sequencer between two requesters and the 4x4 register-file RAM.
// state  | meaning
// INIT   | clear sweep, writes 0 to words 0..3
// IDLE   | waiting for a request, arbitration happens here
// ACCESS | latched access driven onto the RAM
// DONE   | one-cycle ack to the owner
module ram4x4_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       we_a,
  input  logic       we_b,
  input  logic [1:0] addr_a,
  input  logic [1:0] addr_b,
  input  logic [3:0] wdata_a,
  input  logic [3:0] wdata_b,
  output logic       ack_a,
  output logic       ack_b,
  output logic [3:0] rdata_a,
  output logic [3:0] rdata_b,
  output logic [1:0] ram_addr,
  output logic [3:0] ram_d,
  output logic       ram_we,
  input  logic [3:0] ram_q,
  output logic       init_done
);

  typedef enum logic [1:0] {INIT, IDLE, ACCESS, DONE} state_t;

  state_t     state, state_nx;
  logic [1:0] init_cnt;
  logic       last_b;
  logic       owner_b;
  logic       grant_b;
  logic       l_we;
  logic [1:0] l_addr;
  logic [3:0] l_wdata;

  always_comb begin
    state_nx = state;
    grant_b  = req_b & (~req_a | ~last_b);
    ram_addr = l_addr;
    ram_d    = l_wdata;
    ram_we   = 1'b0;
    ack_a    = 1'b0;
    ack_b    = 1'b0;
    case (state)
      INIT: begin
        ram_addr = init_cnt;
        ram_d    = 4'h0;
        ram_we   = 1'b1;
        if (init_cnt == 2'd3) state_nx = IDLE;
      end
      IDLE: begin
        if (req_a || req_b) state_nx = ACCESS;
      end
      ACCESS: begin
        ram_we   = l_we;
        state_nx = DONE;
      end
      DONE: begin
        ack_a    = ~owner_b;
        ack_b    = owner_b;
        state_nx = IDLE;
      end
      default: state_nx = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= INIT;
      init_cnt  <= 2'd0;
      last_b    <= 1'b1;
      owner_b   <= 1'b0;
      l_we      <= 1'b0;
      l_addr    <= 2'd0;
      l_wdata   <= 4'h0;
      rdata_a   <= 4'h0;
      rdata_b   <= 4'h0;
      init_done <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        INIT: begin
          // mirror the sweep into the latches so ram_addr/ram_d hold after INIT
          init_cnt <= init_cnt + 2'd1;
          l_addr   <= init_cnt;
          l_wdata  <= 4'h0;
          if (init_cnt == 2'd3) init_done <= 1'b1;
        end
        IDLE: begin
          if (req_a || req_b) begin
            owner_b <= grant_b;
            last_b  <= grant_b;
            l_we    <= grant_b ? we_b    : we_a;
            l_addr  <= grant_b ? addr_b  : addr_a;
            l_wdata <= grant_b ? wdata_b : wdata_a;
          end
        end
        ACCESS: begin
          if (!l_we) begin
            if (owner_b) rdata_b <= ram_q;
            else         rdata_a <= ram_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram4x4_arbiter.sv
// Directed bench for ram4x4_arbiter with a behavioural 4x4 RAM attached.
module tb_ram4x4_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_a, req_b, we_a, we_b;
  logic [1:0] addr_a, addr_b;
  logic [3:0] wdata_a, wdata_b;
  logic       ack_a, ack_b;
  logic [3:0] rdata_a, rdata_b;
  logic [1:0] ram_addr;
  logic [3:0] ram_d;
  logic       ram_we;
  logic [3:0] ram_q;
  logic       init_done;

  logic [3:0] mem [4];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram4x4_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
    .ack_a(ack_a), .ack_b(ack_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .ram_addr(ram_addr), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q),
    .init_done(init_done)
  );

  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_d;
  assign ram_q = mem[ram_addr];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at a negedge with reset asserted for at least one edge; releases
  // reset and follows the clear sweep until IDLE.
  task automatic init_seq();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("init_we", ram_we, 1'b1);
      chk("init_addr", ram_addr, i[1:0]);
      chk("init_d", ram_d, 4'h0);
      chk("init_done_low", init_done, 1'b0);
      chk("init_noack", {ack_a, ack_b}, 2'b00);
      @(negedge clk);
    end
    chk("init_done_high", init_done, 1'b1);
    chk("idle_we", ram_we, 1'b0);
  endtask

  // Single access, called at a negedge while the block is in IDLE.
  task automatic acc(input bit port_b, input bit we, input logic [1:0] addr,
                     input logic [3:0] wd, input logic [3:0] exp_q);
    if (port_b) begin req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wd; end
    else        begin req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wd; end
    @(negedge clk);
    chk("acc_we", ram_we, we);
    chk("acc_addr", ram_addr, addr);
    if (we) chk("acc_d", ram_d, wd);
    chk("acc_noack", {ack_a, ack_b}, 2'b00);
    @(negedge clk);
    chk("ack_a", ack_a, !port_b);
    chk("ack_b", ack_b, port_b);
    chk("done_we", ram_we, 1'b0);
    if (!we) chk("rdata", port_b ? rdata_b : rdata_a, exp_q);
    req_a = 1'b0;
    req_b = 1'b0;
    @(negedge clk);
    chk("idle_noack", {ack_a, ack_b}, 2'b00);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 4'hF;
    rst_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
    addr_a = 2'd0; addr_b = 2'd0; wdata_a = 4'h0; wdata_b = 4'h0;

    // reset and clear sweep
    repeat (3) @(negedge clk);
    chk("rst_we", ram_we, 1'b1);
    chk("rst_addr", ram_addr, 2'd0);
    chk("rst_rdata", {rdata_a, rdata_b}, 8'h00);
    chk("rst_init_done", init_done, 1'b0);
    init_seq();
    for (int i = 0; i < 4; i++) acc(1'b0, 1'b0, i[1:0], 4'h0, 4'h0);

    // single write/read on A
    acc(1'b0, 1'b1, 2'd2, 4'hA, 4'h0);
    acc(1'b0, 1'b0, 2'd2, 4'h0, 4'hA);

    // B write and A read of addr 0 together, last grant A -> B first
    req_a = 1'b1; we_a = 1'b0; addr_a = 2'd0;
    req_b = 1'b1; we_b = 1'b1; addr_b = 2'd0; wdata_b = 4'h5;
    @(negedge clk);
    chk("x_access_we", ram_we, 1'b1);
    chk("x_access_d", ram_d, 4'h5);
    @(negedge clk);
    chk("x_first_ack", {ack_a, ack_b}, 2'b01);
    req_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("x_read_we", ram_we, 1'b0);
    @(negedge clk);
    chk("x_second_ack", {ack_a, ack_b}, 2'b10);
    chk("x_rdata_a", rdata_a, 4'h5);
    req_a = 1'b0;
    @(negedge clk);

    // seed words 1 and 3 so the next sweep has something to clear
    acc(1'b1, 1'b1, 2'd1, 4'h7, 4'h0);
    acc(1'b1, 1'b1, 2'd3, 4'hC, 4'h0);
    acc(1'b1, 1'b0, 2'd3, 4'h0, 4'hC);

    // requests held through reset and INIT, tie then alternation
    rst_n = 1'b0;
    req_a = 1'b1; we_a = 1'b0; addr_a = 2'd1;
    req_b = 1'b1; we_b = 1'b0; addr_b = 2'd3;
    repeat (2) @(negedge clk);
    chk("rst2_rdata", {rdata_a, rdata_b}, 8'h00);
    init_seq();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("alt_access_noack", {ack_a, ack_b}, 2'b00);
      @(negedge clk);
      chk("alt_ack", {ack_a, ack_b}, (k % 2 == 0) ? 2'b10 : 2'b01);
      chk("alt_rdata", (k % 2 == 0) ? rdata_a : rdata_b, 4'h0);
      if (k == 3) begin req_a = 1'b0; req_b = 1'b0; end
      @(negedge clk);
      chk("alt_idle_noack", {ack_a, ack_b}, 2'b00);
    end

    // reset during an A read aborts it
    acc(1'b0, 1'b1, 2'd1, 4'h9, 4'h0);
    acc(1'b0, 1'b0, 2'd1, 4'h0, 4'h9);
    acc(1'b1, 1'b0, 2'd1, 4'h0, 4'h9);
    req_a = 1'b1; we_a = 1'b0; addr_a = 2'd1;
    @(negedge clk);
    chk("abort_access_addr", ram_addr, 2'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_noack", {ack_a, ack_b}, 2'b00);
    chk("abort_rdata_a", rdata_a, 4'h0);
    chk("abort_rdata_b", rdata_b, 4'h0);
    req_a = 1'b0;
    init_seq();
    for (int i = 0; i < 4; i++) acc(1'b1, 1'b0, i[1:0], 4'h0, 4'h0);
    chk("ram_word1_cleared", mem[1], 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
